// File: rtl/approx_sched_pkg.sv
// Shared types and constants for the approximate-adder scheduler.
//   state_e : scheduler FSM states (IDLE, EXEC, RESP)
//   ADD_W   : operand width of the shared adder
//   SUM_W   : result width of the shared adder
package approx_sched_pkg;

  localparam int ADD_W = 8;
  localparam int SUM_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/approx_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or after the pointer, scanning modulo N_REQ.
//   req     : request vector
//   ptr     : index with the highest priority this cycle
//   gnt_oh  : one-hot grant (all zero when nothing is requested)
//   gnt_idx : encoded grant index (zero when nothing is requested)
//   any     : at least one request is set
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  always_comb begin
    int   idx;
    logic found;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = ID_W'(idx);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/approx_add_sched.sv
// Round-robin scheduler sharing one external 8-bit approximate adder among
// N_REQ requesters. One operation in flight: IDLE (grant) -> EXEC (adder
// driven from registered operands, sum captured) -> RESP (hold until taken).
//   clk, rst_n            : clock, synchronous active-low reset
//   REQ_VALID/A/B         : per-requester request and packed operands
//   REQ_READY             : one-hot accept strobe, only in IDLE
//   ADD_A/ADD_B, ADD_O    : shared adder operands (zero outside EXEC) and sum
//   RSP_VALID/READY       : result handshake
//   RSP_SUM, RSP_ID       : captured adder output and owning requester
//   BUSY                  : state is not IDLE
//   OPS_CNT               : saturating count of completed responses
module approx_add_sched
  import approx_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [N_REQ*8-1:0] REQ_A,
  input  logic [N_REQ*8-1:0] REQ_B,
  output logic [N_REQ-1:0]   REQ_READY,
  output logic [7:0]         ADD_A,
  output logic [7:0]         ADD_B,
  input  logic [8:0]         ADD_O,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [8:0]         RSP_SUM,
  output logic [ID_W-1:0]    RSP_ID,
  output logic               BUSY,
  output logic [CNT_W-1:0]   OPS_CNT
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADD_W-1:0]   a_q, a_d;
  logic [ADD_W-1:0]   b_q, b_d;

  logic [N_REQ-1:0]   gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [ADD_W-1:0]   sel_a, sel_b;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req     (REQ_VALID),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = REQ_A[i*ADD_W +: ADD_W];
        sel_b = REQ_B[i*ADD_W +: ADD_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    REQ_READY = '0;
    ADD_A     = '0;
    ADD_B     = '0;
    unique case (state_q)
      IDLE: begin
        // No grant is shown while reset is held, so REQ_READY reads zero.
        if (gnt_any && rst_n) begin
          REQ_READY = gnt_oh;
          a_d       = sel_a;
          b_d       = sel_b;
          id_d      = gnt_idx;
          // Served requester drops to lowest priority next time.
          ptr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        ADD_A   = a_q;
        ADD_B   = b_q;
        sum_d   = ADD_O;
        state_d = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand registers are only observed in EXEC, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign RSP_VALID = (state_q == RESP);
  assign RSP_SUM   = sum_q;
  assign RSP_ID    = id_q;
  assign BUSY      = (state_q != IDLE);
  assign OPS_CNT   = cnt_q;

endmodule

// File: tb/tb_approx_add_sched.sv
module tb_approx_add_sched;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [7:0]        op_a [NR];
  logic [7:0]        op_b [NR];
  logic [NR*8-1:0]   req_a, req_b;
  logic [NR-1:0]     req_ready;
  logic [7:0]        add_a, add_b;
  logic [8:0]        add_o;
  logic              rsp_valid, rsp_ready;
  logic [8:0]        rsp_sum;
  logic [IW-1:0]     rsp_id;
  logic              busy;
  logic [CW-1:0]     ops_cnt;
  bit                stub_fixed;

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_a[gi*8 +: 8] = op_a[gi];
    assign req_b[gi*8 +: 8] = op_b[gi];
  end

  // Adder stub: exact sum, or a fixed value to prove pass-through.
  assign add_o = stub_fixed ? 9'h040 : ({1'b0, add_a} + {1'b0, add_b});

  approx_add_sched #(.N_REQ(NR), .ID_W(IW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_A     (req_a),
    .REQ_B     (req_b),
    .REQ_READY (req_ready),
    .ADD_A     (add_a),
    .ADD_B     (add_b),
    .ADD_O     (add_o),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_SUM   (rsp_sum),
    .RSP_ID    (rsp_id),
    .BUSY      (busy),
    .OPS_CNT   (ops_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected result pushed when a grant is seen, popped on handshake.
  typedef struct {
    logic [IW-1:0] id;
    logic [8:0]    sum;
  } exp_t;
  exp_t sbq[$];
  int   m_ptr = 0;

  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (!rst_n) begin
      sbq.delete();
      m_ptr = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("sb_sum", rsp_sum, e.sum);
          chk("sb_id", rsp_id, e.id);
        end
      end
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        if (g < 0) chk("sb_spurious_grant", req_ready, 32'd0);
        else begin
          chk("sb_grant", req_ready, 32'd1 << g);
          e.id  = IW'(g);
          e.sum = stub_fixed ? 9'h040 : ({1'b0, op_a[g]} + {1'b0, op_b[g]});
          sbq.push_back(e);
          m_ptr = (g + 1) % NR;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] vld;
    logic [7:0] a;
    logic [7:0] b;
    bit         fixed;
    logic [1:0] id;
    logic [8:0] sum;
  } vec_t;
  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int bound);
    for (int n = 0; n < bound && !rsp_valid; n++) tick();
    chk("rsp_timeout", rsp_valid, 32'd1);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 20 && busy; n++) tick();
    chk("drain_idle", busy, 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid[$];
    int gcyc[$];
    int hs;
    logic pend;
    logic [8:0] hold_sum;

    tbl[0] = '{4'b0001, 8'h05, 8'h03, 1'b0, 2'd0, 9'h008};
    tbl[1] = '{4'b0001, 8'hFF, 8'hFF, 1'b0, 2'd0, 9'h1FE};
    tbl[2] = '{4'b1111, 8'h10, 8'h20, 1'b0, 2'd1, 9'h030};
    tbl[3] = '{4'b0011, 8'h01, 8'h02, 1'b0, 2'd0, 9'h003};
    tbl[4] = '{4'b1000, 8'h80, 8'h80, 1'b0, 2'd3, 9'h100};
    tbl[5] = '{4'b0110, 8'hFF, 8'hFF, 1'b1, 2'd1, 9'h040};
    tbl[6] = '{4'b0101, 8'h7F, 8'h01, 1'b0, 2'd2, 9'h080};
    tbl[7] = '{4'b0011, 8'h00, 8'h00, 1'b0, 2'd0, 9'h000};

    stub_fixed = 1'b0;
    for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_cnt", ops_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Single request: same-cycle ready, result two cycles later.
    op_a[0] = 8'h05; op_b[0] = 8'h03; req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    chk("single_ready", req_ready, 4'b0001);
    chk("single_busy_idle", busy, 0);
    tick(); req_valid = '0; #1;
    chk("single_exec_busy", busy, 1);
    chk("single_add_a", add_a, 8'h05);
    chk("single_add_b", add_b, 8'h03);
    chk("single_exec_rsp_valid", rsp_valid, 0);
    chk("single_exec_ready", req_ready, 0);
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_sum", rsp_sum, 9'h008);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_cnt_before", ops_cnt, 0);
    tick();
    chk("single_rsp_done", rsp_valid, 0);
    chk("single_cnt_after", ops_cnt, 1);

    // Vector table, starting from a fresh pointer.
    do_reset();
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      stub_fixed = tbl[v].fixed;
      for (int i = 0; i < NR; i++) begin op_a[i] = tbl[v].a; op_b[i] = tbl[v].b; end
      req_valid = tbl[v].vld;
      tick();
      req_valid = '0;
      wait_rsp(10);
      chk($sformatf("tbl%0d_sum", v), rsp_sum, tbl[v].sum);
      chk($sformatf("tbl%0d_id", v), rsp_id, tbl[v].id);
      tick();
    end
    stub_fixed = 1'b0;
    chk("tbl_ops_cnt", ops_cnt, 8);

    // Round robin with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < NR; i++) begin op_a[i] = 8'(i); op_b[i] = 8'h10; end
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (req_ready != '0)
        for (int i = 0; i < NR; i++)
          if (req_ready[i]) begin gid.push_back(i); gcyc.push_back(cyc); end
      tick(); #1;
    end
    for (int k = 0; k < 5; k++) begin
      if (k < gid.size()) chk($sformatf("rr_order%0d", k), gid[k], k % NR);
      else chk($sformatf("rr_missing%0d", k), 0, 1);
      if (k > 0 && k < gcyc.size()) chk($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
    end
    drain();

    // Backpressure in RESP.
    op_a[2] = 8'h33; op_b[2] = 8'h44; rsp_ready = 1'b0; req_valid = 4'b0100;
    tick();
    req_valid = 4'hF;
    wait_rsp(10);
    hold_sum = 9'h077;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_sum_stable", rsp_sum, hold_sum);
      chk("bp_id_stable", rsp_id, 2);
      chk("bp_ready_zero", req_ready, 0);
      chk("bp_valid_held", rsp_valid, 1);
      tick();
    end
    rsp_ready = 1'b1; #1;
    chk("bp_hs_no_grant", req_ready, 0);
    tick(); #1;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_grant", req_ready, 4'b1000);
    tick();
    drain();

    // Reset asserted in EXEC with three completed operations.
    do_reset();
    rsp_ready = 1'b1;
    op_a[0] = 8'h01; op_b[0] = 8'h01;
    for (int n = 0; n < 3; n++) begin
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp(10);
      tick();
    end
    chk("rstx_cnt3", ops_cnt, 3);
    op_a[1] = 8'h09; op_b[1] = 8'h09; req_valid = 4'b0010;
    tick();
    chk("rstx_in_exec", busy, 1);
    chk("rstx_add_a", add_a, 8'h09);
    rst_n = 1'b0;
    tick(); #1;
    chk("rstx_req_ready", req_ready, 0);
    chk("rstx_add_a0", add_a, 0);
    chk("rstx_add_b0", add_b, 0);
    chk("rstx_rsp_valid", rsp_valid, 0);
    chk("rstx_rsp_sum", rsp_sum, 0);
    chk("rstx_rsp_id", rsp_id, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_cnt0", ops_cnt, 0);
    rst_n = 1'b1; #1;
    chk("rstx_regrant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_rsp(10);
    chk("rstx_sum", rsp_sum, 9'h012);
    chk("rstx_id", rsp_id, 1);
    tick();
    chk("rstx_cnt1", ops_cnt, 1);

    // Counter saturation (CW bits here, same logic as the 16-bit default).
    do_reset();
    op_a[0] = 8'h02; op_b[0] = 8'h03; req_valid = 4'b0001; rsp_ready = 1'b1;
    hs = 0;
    for (int n = 0; n < 400 && hs < 66; n++) begin
      pend = rsp_valid && rsp_ready;
      tick();
      if (pend) begin
        hs++;
        if (hs == 62) chk("sat_cnt62", ops_cnt, 62);
        if (hs == 63) chk("sat_cnt63", ops_cnt, 63);
        if (hs == 66) chk("sat_hold", ops_cnt, 63);
      end
    end
    chk("sat_done", hs, 66);
    drain();

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
